// File: rtl/frame_streamer_pkg.sv
// Shared types for the raster pixel source: FSM state encoding, the per-pixel
// tag carried alongside the memory read, and the helper that derives its flags.
package frame_streamer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_HBLANK,
        ST_VBLANK,
        ST_DRAIN
    } frame_streamer_state_t;

    typedef struct packed {
        logic        valid;
        logic [15:0] col;
        logic [15:0] row;
        logic        sof;
        logic        eol;
        logic        eof;
    } pixel_tag_t;

    // Invalid slots are fully zeroed so stall bubbles never carry stale coordinates.
    function automatic pixel_tag_t make_tag(
        input logic        valid,
        input logic [15:0] col,
        input logic [15:0] row,
        input logic [15:0] last_col,
        input logic [15:0] last_row
    );
        pixel_tag_t tag;
        tag = '0;
        if (valid) begin
            tag.valid = 1'b1;
            tag.col   = col;
            tag.row   = row;
            tag.sof   = (col == 16'd0) && (row == 16'd0);
            tag.eol   = (col == last_col);
            tag.eof   = (col == last_col) && (row == last_row);
        end
        return tag;
    endfunction

endpackage

// File: rtl/frame_streamer_tag_delay_line.sv
// Fixed-depth shift register that holds pixel tags while their memory read is
// in flight; empty_o reports that no valid tag remains anywhere in the line.
module tag_delay_line
    import frame_streamer_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  pixel_tag_t tag_i,
    output pixel_tag_t tag_o,
    output logic       empty_o
);

    pixel_tag_t stage_q [DEPTH];
    pixel_tag_t stage_d [DEPTH];

    always_comb begin
        stage_d[0] = tag_i;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    always_comb begin
        empty_o = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (stage_q[i].valid) begin
                empty_o = 1'b0;
            end
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/frame_streamer.sv
// Raster-scan pixel source: walks the stored image in row-major order, issues
// synchronous memory reads and emits each pixel with its column/row/frame tags.
module frame_streamer
    import frame_streamer_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int ADDR_WIDTH   = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT),
    parameter int READ_LATENCY = 1,
    parameter int H_BLANK      = 0,
    parameter int V_BLANK      = 0,
    parameter int CONTINUOUS   = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic                  stall_i,
    output logic                  rd_en_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [15:0]           col_o,
    output logic [15:0]           row_o,
    output logic                  valid_o,
    output logic                  sof_o,
    output logic                  eol_o,
    output logic                  eof_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam logic [15:0] LAST_COL = 16'(IMAGE_WIDTH - 1);
    localparam logic [15:0] LAST_ROW = 16'(IMAGE_HEIGHT - 1);
    localparam logic [15:0] HB_LAST  = (H_BLANK > 0) ? 16'(H_BLANK - 1) : 16'd0;
    localparam logic [15:0] VB_LAST  = (V_BLANK > 0) ? 16'(V_BLANK - 1) : 16'd0;

    frame_streamer_state_t state_q, state_d;
    logic [15:0]           col_q, col_d;
    logic [15:0]           row_q, row_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           blank_q, blank_d;
    logic                  stop_q, stop_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    pixel_tag_t            out_tag_q, out_tag_d;

    logic       rd_en;
    logic       restart;
    pixel_tag_t tag_in;
    pixel_tag_t tag_dly;
    logic       line_empty;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        addr_d  = addr_q;
        blank_d = blank_q;
        done_d  = 1'b0;
        rd_en   = 1'b0;
        stop_d  = (state_q == ST_IDLE) ? 1'b0 : (stop_q | stop_i);
        restart = (CONTINUOUS != 0) && !(stop_q || stop_i);

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_ACTIVE;
                    col_d   = '0;
                    row_d   = '0;
                    addr_d  = '0;
                end
            end
            ST_ACTIVE: begin
                if (!stall_i) begin
                    rd_en = 1'b1;
                    if (col_q != LAST_COL) begin
                        col_d  = col_q + 16'd1;
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end else if (row_q != LAST_ROW) begin
                        col_d  = '0;
                        row_d  = row_q + 16'd1;
                        addr_d = addr_q + ADDR_WIDTH'(1);
                        if (H_BLANK > 0) begin
                            state_d = ST_HBLANK;
                            blank_d = '0;
                        end
                    end else begin
                        col_d  = '0;
                        row_d  = '0;
                        addr_d = '0;
                        if (V_BLANK > 0) begin
                            state_d = ST_VBLANK;
                            blank_d = '0;
                        end else begin
                            state_d = restart ? ST_ACTIVE : ST_DRAIN;
                        end
                    end
                end
            end
            ST_HBLANK: begin
                if (blank_q == HB_LAST) begin
                    state_d = ST_ACTIVE;
                end else begin
                    blank_d = blank_q + 16'd1;
                end
            end
            ST_VBLANK: begin
                if (blank_q == VB_LAST) begin
                    state_d = restart ? ST_ACTIVE : ST_DRAIN;
                end else begin
                    blank_d = blank_q + 16'd1;
                end
            end
            ST_DRAIN: begin
                if (line_empty) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign tag_in = make_tag(rd_en, col_q, row_q, LAST_COL, LAST_ROW);

    tag_delay_line #(
        .DEPTH(READ_LATENCY)
    ) u_tag_delay_line (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .tag_i   (tag_in),
        .tag_o   (tag_dly),
        .empty_o (line_empty)
    );

    // The delayed tag lines up with rd_data_i; both are captured together here.
    always_comb begin
        out_tag_d = tag_dly;
        data_d    = tag_dly.valid ? rd_data_i : '0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            col_q     <= '0;
            row_q     <= '0;
            addr_q    <= '0;
            blank_q   <= '0;
            stop_q    <= 1'b0;
            done_q    <= 1'b0;
            data_q    <= '0;
            out_tag_q <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            addr_q    <= addr_d;
            blank_q   <= blank_d;
            stop_q    <= stop_d;
            done_q    <= done_d;
            data_q    <= data_d;
            out_tag_q <= out_tag_d;
        end
    end

    assign rd_en_o   = rd_en;
    assign rd_addr_o = addr_q;
    assign data_o    = data_q;
    assign col_o     = out_tag_q.col;
    assign row_o     = out_tag_q.row;
    assign valid_o   = out_tag_q.valid;
    assign sof_o     = out_tag_q.sof;
    assign eol_o     = out_tag_q.eol;
    assign eof_o     = out_tag_q.eof;
    assign busy_o    = (state_q != ST_IDLE);
    assign done_o    = done_q;

endmodule

// File: tb/tb_frame_streamer.sv
// Self-checking bench for frame_streamer: four differently parameterised
// instances share one clock and are exercised one at a time.
module tb_frame_streamer;

    typedef struct {
        int inst;
        int addr;
        int data;
        int col;
        int row;
        bit sof;
        bit eol;
        bit eof;
    } pix_t;

    typedef struct {
        int inst;
        int w;
        int h;
        int stallAt;
        int stallLen;
        int expPix;
        int expSpan;
    } scen_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;

    logic        start_s [4];
    logic        stop_s  [4];
    logic        stall_s [4];
    logic        rden_s  [4];
    logic        valid_s [4];
    logic        sof_s   [4];
    logic        eol_s   [4];
    logic        eof_s   [4];
    logic        busy_s  [4];
    logic        done_s  [4];
    logic [7:0]  data_s  [4];
    logic [7:0]  rdata_s [4];
    logic [15:0] col_s   [4];
    logic [15:0] row_s   [4];
    logic [15:0] addr_s  [4];
    logic [7:0]  memPipe [4][3];

    logic [3:0] addr0;
    logic [1:0] addr1;
    logic [3:0] addr2;
    logic [0:0] addr3;

    assign addr_s[0] = 16'(addr0);
    assign addr_s[1] = 16'(addr1);
    assign addr_s[2] = 16'(addr2);
    assign addr_s[3] = 16'(addr3);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read memory model whose contents equal the address.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            memPipe[i][0] <= addr_s[i][7:0];
            memPipe[i][1] <= memPipe[i][0];
            memPipe[i][2] <= memPipe[i][1];
        end
    end

    assign rdata_s[0] = memPipe[0][0];
    assign rdata_s[1] = memPipe[1][0];
    assign rdata_s[2] = memPipe[2][2];
    assign rdata_s[3] = memPipe[3][0];

    frame_streamer #(.DATA_WIDTH(8), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(3), .ADDR_WIDTH(4),
                     .READ_LATENCY(1), .H_BLANK(0), .V_BLANK(0), .CONTINUOUS(0)) u_dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start_s[0]), .stop_i(stop_s[0]),
        .stall_i(stall_s[0]), .rd_en_o(rden_s[0]), .rd_addr_o(addr0), .rd_data_i(rdata_s[0]),
        .data_o(data_s[0]), .col_o(col_s[0]), .row_o(row_s[0]), .valid_o(valid_s[0]),
        .sof_o(sof_s[0]), .eol_o(eol_s[0]), .eof_o(eof_s[0]), .busy_o(busy_s[0]), .done_o(done_s[0]));

    frame_streamer #(.DATA_WIDTH(8), .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2), .ADDR_WIDTH(2),
                     .READ_LATENCY(1), .H_BLANK(2), .V_BLANK(3), .CONTINUOUS(1)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start_s[1]), .stop_i(stop_s[1]),
        .stall_i(stall_s[1]), .rd_en_o(rden_s[1]), .rd_addr_o(addr1), .rd_data_i(rdata_s[1]),
        .data_o(data_s[1]), .col_o(col_s[1]), .row_o(row_s[1]), .valid_o(valid_s[1]),
        .sof_o(sof_s[1]), .eol_o(eol_s[1]), .eof_o(eof_s[1]), .busy_o(busy_s[1]), .done_o(done_s[1]));

    frame_streamer #(.DATA_WIDTH(8), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(3), .ADDR_WIDTH(4),
                     .READ_LATENCY(3), .H_BLANK(0), .V_BLANK(0), .CONTINUOUS(0)) u_dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start_s[2]), .stop_i(stop_s[2]),
        .stall_i(stall_s[2]), .rd_en_o(rden_s[2]), .rd_addr_o(addr2), .rd_data_i(rdata_s[2]),
        .data_o(data_s[2]), .col_o(col_s[2]), .row_o(row_s[2]), .valid_o(valid_s[2]),
        .sof_o(sof_s[2]), .eol_o(eol_s[2]), .eof_o(eof_s[2]), .busy_o(busy_s[2]), .done_o(done_s[2]));

    frame_streamer #(.DATA_WIDTH(8), .IMAGE_WIDTH(1), .IMAGE_HEIGHT(1), .ADDR_WIDTH(1),
                     .READ_LATENCY(1), .H_BLANK(0), .V_BLANK(0), .CONTINUOUS(0)) u_dut3 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start_s[3]), .stop_i(stop_s[3]),
        .stall_i(stall_s[3]), .rd_en_o(rden_s[3]), .rd_addr_o(addr3), .rd_data_i(rdata_s[3]),
        .data_o(data_s[3]), .col_o(col_s[3]), .row_o(row_s[3]), .valid_o(valid_s[3]),
        .sof_o(sof_s[3]), .eol_o(eol_s[3]), .eof_o(eof_s[3]), .busy_o(busy_s[3]), .done_o(done_s[3]));

    int   checkCount = 0;
    int   passCount  = 0;
    int   phase      = 0;
    int   seenPhase  = -1;
    int   rdCount, valCount, doneCount;
    int   firstRd, lastRd, firstVal, lastVal, doneCyc;
    pix_t pixQ [$];
    pix_t rdQ  [$];
    int   issQ [$];
    int   rdCyc [$];
    scen_t scen [4];
    int   expOff [8];

    function automatic int latOf(input int i);
        return (i == 2) ? 3 : 1;
    endfunction

    function automatic logic [63:0] packPix(input logic [7:0] inst, input logic [7:0] data,
                                            input logic [15:0] col, input logic [15:0] row,
                                            input logic sof, input logic eol, input logic eof);
        return {inst, data, col, row, 13'd0, sof, eol, eof};
    endfunction

    function automatic logic [63:0] outVec(input int i);
        return 64'({busy_s[i], rden_s[i], addr_s[i], valid_s[i], data_s[i], col_s[i],
                    row_s[i], sof_s[i], eol_s[i], eof_s[i], done_s[i]});
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        checkCount++;
        if (actual === required) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, required, cyc);
    endtask

    task automatic reportFail(input string name, input logic [63:0] actual);
        checkCount++;
        $display("[TB] FAIL %s: got %h, expected nothing (cycle %0d)", name, actual, cyc);
    endtask

    // Expected raster order for one frame; memory data equals the address.
    task automatic pushFrame(input int inst, input int w, input int h);
        pix_t e;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                e.inst = inst;
                e.addr = r * w + c;
                e.data = (r * w + c) % 256;
                e.col  = c;
                e.row  = r;
                e.sof  = (c == 0) && (r == 0);
                e.eol  = (c == w - 1);
                e.eof  = (c == w - 1) && (r == h - 1);
                pixQ.push_back(e);
                rdQ.push_back(e);
            end
        end
    endtask

    task automatic monitorLoop();
        pix_t e;
        int   iss;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pixQ.delete();
                rdQ.delete();
                issQ.delete();
            end else begin
                if (phase != seenPhase) begin
                    seenPhase = phase;
                    rdCount = 0; valCount = 0; doneCount = 0;
                    firstRd = -1; lastRd = -1; firstVal = -1; lastVal = -1; doneCyc = -1;
                    rdCyc.delete();
                end
                for (int i = 0; i < 4; i++) begin
                    if (rden_s[i] === 1'b1) begin
                        rdCount++;
                        if (firstRd < 0) firstRd = cyc;
                        lastRd = cyc;
                        rdCyc.push_back(cyc);
                        issQ.push_back(cyc);
                        if (rdQ.size() == 0) reportFail("unexpected_read", 64'({8'(i), addr_s[i]}));
                        else begin
                            e = rdQ.pop_front();
                            checkOutput("rd_addr", 64'({8'(i), addr_s[i]}), 64'({8'(e.inst), 16'(e.addr)}));
                        end
                    end
                    if (valid_s[i] === 1'b1) begin
                        valCount++;
                        if (firstVal < 0) firstVal = cyc;
                        lastVal = cyc;
                        if (pixQ.size() == 0) reportFail("unexpected_pixel", 64'({8'(i), col_s[i], row_s[i]}));
                        else begin
                            e = pixQ.pop_front();
                            checkOutput("pixel",
                                packPix(8'(i), data_s[i], col_s[i], row_s[i], sof_s[i], eol_s[i], eof_s[i]),
                                packPix(8'(e.inst), 8'(e.data), 16'(e.col), 16'(e.row), e.sof, e.eol, e.eof));
                        end
                        if (issQ.size() > 0) begin
                            iss = issQ.pop_front();
                            checkOutput("latency", 64'(cyc - iss), 64'(latOf(i) + 1));
                        end
                    end
                    if (done_s[i] === 1'b1) begin
                        doneCount++;
                        doneCyc = cyc;
                    end
                end
            end
        end
    endtask

    task automatic pulseStart(input int inst);
        @(posedge clk); #1 start_s[inst] = 1'b1;
        @(posedge clk); #1 start_s[inst] = 1'b0;
    endtask

    task automatic applyStimulus(input scen_t s);
        phase++;
        pushFrame(s.inst, s.w, s.h);
        pulseStart(s.inst);
        for (int c = 0; c < 60; c++) begin
            stall_s[s.inst] = (s.stallLen > 0) && (c >= s.stallAt) && (c < s.stallAt + s.stallLen);
            @(posedge clk); #1;
        end
        stall_s[s.inst] = 1'b0;
    endtask

    task automatic checkScenario(input scen_t s);
        checkOutput("pix_count", 64'(valCount), 64'(s.expPix));
        checkOutput("rd_count", 64'(rdCount), 64'(s.expPix));
        checkOutput("rd_span", 64'(lastRd - firstRd + 1), 64'(s.expSpan));
        checkOutput("valid_span", 64'(lastVal - firstVal + 1), 64'(s.expSpan));
        checkOutput("first_latency", 64'(firstVal - firstRd), 64'(latOf(s.inst) + 1));
        checkOutput("done_count", 64'(doneCount), 64'(1));
        checkOutput("done_after_eof", 64'(doneCyc), 64'(lastVal + 1));
        checkOutput("busy_idle", 64'(busy_s[s.inst]), 64'(0));
        checkOutput("queue_drained", 64'(pixQ.size()), 64'(0));
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            start_s[i] = 1'b0;
            stop_s[i]  = 1'b0;
            stall_s[i] = 1'b0;
        end
        scen[0] = '{inst: 0, w: 4, h: 3, stallAt: -1, stallLen: 0, expPix: 12, expSpan: 12};
        scen[1] = '{inst: 0, w: 4, h: 3, stallAt: 5,  stallLen: 3, expPix: 12, expSpan: 15};
        scen[2] = '{inst: 2, w: 4, h: 3, stallAt: -1, stallLen: 0, expPix: 12, expSpan: 12};
        scen[3] = '{inst: 2, w: 4, h: 3, stallAt: 2,  stallLen: 1, expPix: 12, expSpan: 13};
        expOff  = '{0, 1, 4, 5, 9, 10, 13, 14};

        fork
            monitorLoop();
        join_none

        #1 rst_n = 1'b0;
        #2;
        for (int i = 0; i < 4; i++) checkOutput("reset_outputs", outVec(i), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int k = 0; k < 4; k++) begin
            applyStimulus(scen[k]);
            checkScenario(scen[k]);
        end

        // Abort a frame mid-row 2 with an asynchronous reset, then restart it.
        phase++;
        pushFrame(0, 4, 3);
        pulseStart(0);
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 checkOutput("async_reset_outputs", outVec(0), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checkOutput("abort_no_done", 64'(doneCount), 64'(0));
        checkOutput("abort_idle", 64'(busy_s[0]), 64'(0));
        applyStimulus(scen[0]);
        checkScenario(scen[0]);

        // Continuous 2x2 with blanking: start and stop together, then stop in frame 2.
        phase++;
        pushFrame(1, 2, 2);
        pushFrame(1, 2, 2);
        @(posedge clk); #1 start_s[1] = 1'b1; stop_s[1] = 1'b1;
        @(posedge clk); #1 start_s[1] = 1'b0; stop_s[1] = 1'b0;
        for (int c = 0; c < 50; c++) begin
            stop_s[1] = (c == 11);
            @(posedge clk); #1;
        end
        stop_s[1] = 1'b0;
        checkOutput("cont_rd_count", 64'(rdCount), 64'(8));
        checkOutput("cont_pix_count", 64'(valCount), 64'(8));
        checkOutput("cont_done_count", 64'(doneCount), 64'(1));
        checkOutput("cont_busy_idle", 64'(busy_s[1]), 64'(0));
        checkOutput("cont_queue_drained", 64'(pixQ.size()), 64'(0));
        for (int k = 0; k < 8 && k < rdCyc.size(); k++) begin
            checkOutput("cont_rd_offset", 64'(rdCyc[k] - rdCyc[0]), 64'(expOff[k]));
        end

        // 1x1 image with start re-asserted while busy.
        phase++;
        pushFrame(3, 1, 1);
        pulseStart(3);
        @(posedge clk); #1 start_s[3] = 1'b1;
        checkOutput("single_busy", 64'(busy_s[3]), 64'(1));
        @(posedge clk); #1;
        @(posedge clk); #1 start_s[3] = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("single_rd_count", 64'(rdCount), 64'(1));
        checkOutput("single_pix_count", 64'(valCount), 64'(1));
        checkOutput("single_done_count", 64'(doneCount), 64'(1));
        checkOutput("single_done_after_eof", 64'(doneCyc), 64'(lastVal + 1));
        checkOutput("single_busy_idle", 64'(busy_s[3]), 64'(0));
        checkOutput("single_queue_drained", 64'(pixQ.size()), 64'(0));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/frame_streamer.md
Name: frame_streamer

Overview:
- Raster-scan pixel source: reads a stored image from a synchronous-read memory port and emits it as a tagged pixel stream (data, col, row, valid).
- The stream is the push-in format consumed by the line-buffer and window-fetcher blocks.
- Sits between frame-buffer BRAM and the image-processing pipeline.
- Supports stall gaps, programmable horizontal/vertical blanking and continuous frame looping.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- IMAGE_WIDTH, 640, pixels per row, 1..65535.
- IMAGE_HEIGHT, 480, rows per frame, 1..65535.
- ADDR_WIDTH, $clog2(IMAGE_WIDTH*IMAGE_HEIGHT), memory address width.
- READ_LATENCY, 1, memory cycles from rd_en_o to rd_data_i valid, >=1.
- H_BLANK, 0, idle cycles inserted after each row except the last.
- V_BLANK, 0, idle cycles inserted after the last row of a frame.
- CONTINUOUS, 0, 1 = restart the next frame automatically after V_BLANK.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset; one clock, reset is asynchronous and active-low.
- start_i  in  1  begin one frame (or a continuous run); sampled only in IDLE.
- stop_i  in  1  CONTINUOUS mode: finish the current frame, then go idle.
- stall_i  in  1  suppress new reads this cycle.
- rd_en_o  out  1  memory read strobe.
- rd_addr_o  out  ADDR_WIDTH  memory read address.
- rd_data_i  in  DATA_WIDTH  memory read data.
- data_o  out  DATA_WIDTH  pixel.
- col_o  out  16  pixel column.
- row_o  out  16  pixel row.
- valid_o  out  1  pixel valid.
- sof_o  out  1  qualifies col=0,row=0 (only with valid_o).
- eol_o  out  1  qualifies col=IMAGE_WIDTH-1.
- eof_o  out  1  qualifies the last pixel of the frame.
- busy_o  out  1  high from start acceptance until done.
- done_o  out  1  one-cycle pulse when the frame has fully drained.

Behaviour:
- Reset (asynchronous, rst_n_i=0):
  - state IDLE; counters zero; tag pipeline flushed.
  - All outputs 0.
  - Reset mid-frame aborts the frame with no done_o pulse.
- FSM states: IDLE, ACTIVE, HBLANK, VBLANK, DRAIN.
- IDLE:
  - start_i=1 -> ACTIVE, with col=row=addr=0 and busy_o=1 from the next cycle.
- ACTIVE:
  - Cycle with stall_i=0: rd_en_o=1, rd_addr_o=addr, tags (col,row,sof,eol,eof) pushed into the delay line.
  - After the issue, addr+1 and col+1.
  - At col=IMAGE_WIDTH-1, col wraps to 0 and row+1. Next state is HBLANK if H_BLANK>0 and not the last row; VBLANK if last row and V_BLANK>0; else the row/frame-end rule below.
  - Cycle with stall_i=1: rd_en_o=0, counters hold, and an invalid slot enters the delay line.
- HBLANK: counts H_BLANK cycles with rd_en_o=0, then returns to ACTIVE.
- VBLANK: counts V_BLANK cycles with rd_en_o=0.
- Frame end (after the last issue, post-VBLANK):
  - CONTINUOUS=1 and no stop latched -> ACTIVE, with row=col=addr=0.
  - Otherwise -> DRAIN.
  - stop_i is latched on any cycle while busy and cleared in IDLE.
- DRAIN: waits until the delay line is empty, then pulses done_o for 1 cycle, drops busy_o and returns to IDLE.
  - done_o asserts the cycle after the eof valid_o.
- Latency and output register:
  - Tags are delayed READ_LATENCY cycles to align with rd_data_i, then registered with the data.
  - valid_o follows rd_en_o by exactly READ_LATENCY+1 cycles, with col/row/flags aligned.
  - Stall gaps propagate as valid_o=0 gaps. Reads already in flight always complete; there is no backpressure beyond stall_i.
- Boundary conditions:
  - IMAGE_WIDTH=1: eol on every pixel.
  - IMAGE_HEIGHT=1: HBLANK is never entered.
  - 1x1 image: sof, eol and eof on the same pixel.
- start_i while busy is ignored. Simultaneous start_i and stop_i in IDLE: start is accepted and stop is ignored.
- Arithmetic:
  - addr wraps at IMAGE_WIDTH*IMAGE_HEIGHT-1 -> 0.
  - Blank counters are 16 bits.
  - col/row are zero-extended to 16 bits.

Decomposition:
- Package frame_streamer_pkg holds:
  - the state enum frame_streamer_state_t;
  - the tag struct {valid, col, row, sof, eol, eof};
  - the helper function for the flag computation.
- Sub-module tag_delay_line: READ_LATENCY-deep shift register of the tag struct, with asynchronous active-low clear and an occupancy flag "empty" used by DRAIN.

Test Plan:
- 4x3 image, READ_LATENCY=1, start_i pulse, no stall:
  - rd_addr_o 0..11 on consecutive cycles.
  - valid_o high for 12 consecutive cycles starting 2 cycles after the first rd_en_o.
  - (col,row) sequence (0,0)..(3,2).
  - sof on the 1st pixel, eol on pixels 4/8/12, eof on the 12th.
  - done_o the cycle after, then busy_o=0.
- Same 4x3 image, stall_i high on 3 cycles mid-row 1:
  - exactly 3 valid_o gaps;
  - pixel order and data unchanged;
  - total 12 valid pixels.
- H_BLANK=2, V_BLANK=3, CONTINUOUS=1, 2x2 image, stop_i asserted during frame 2:
  - 2 rd_en_o-idle cycles between rows;
  - 3 cycles between frames;
  - exactly 2 frames (8 pixels) output;
  - a single done_o.
- READ_LATENCY=3, memory model returning data=addr:
  - data_o equals row*W+col on every valid_o.
  - 4-cycle issue-to-valid latency.
- rst_n_i asserted asynchronously mid-row 2:
  - all outputs 0 immediately, with no clock edge required;
  - no done_o;
  - a new start_i restarts at addr 0 with sof.
- 1x1 image:
  - a single pixel with sof=eol=eof=1;
  - start_i during busy ignored (addr never re-issued).
